// File: rtl/mem_port_arbiter.sv
// Shares one memory port between IFU and LSU. One transaction is in flight at a time:
// accept in IDLE, issue a 1-cycle request in REQ, then wait for the response in WAIT.
module mem_port_arbiter #(
    parameter int MAX_LSU_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [31:0] ifu_addr,
    output logic        ifu_resp_valid,
    output logic [31:0] ifu_rdata,
    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic [31:0] lsu_addr,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wmask,
    output logic        lsu_resp_valid,
    output logic [31:0] lsu_rdata,
    output logic        mem_req_valid,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_rdata
);

    localparam int SW = $clog2(MAX_LSU_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LSU_STREAK);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          owner;
    logic [SW-1:0] streak;
    logic          grant_lsu;
    logic          grant_ifu;

    always_comb begin
        state_nxt      = state;
        grant_lsu      = 1'b0;
        grant_ifu      = 1'b0;
        ifu_req_ready  = 1'b0;
        lsu_req_ready  = 1'b0;
        ifu_resp_valid = 1'b0;
        lsu_resp_valid = 1'b0;
        ifu_rdata      = 32'h0;
        lsu_rdata      = 32'h0;
        case (state)
            IDLE: begin
                // Handshakes are suppressed while rst is high so no master sees a phantom accept.
                if (!rst) begin
                    if (lsu_req_valid && !(ifu_req_valid && streak == STREAK_MAX)) begin
                        grant_lsu = 1'b1;
                    end else if (ifu_req_valid) begin
                        grant_ifu = 1'b1;
                    end
                    lsu_req_ready = grant_lsu;
                    ifu_req_ready = grant_ifu;
                    if (grant_lsu || grant_ifu) begin
                        state_nxt = REQ;
                    end
                end
            end
            REQ: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    state_nxt = IDLE;
                    if (!rst) begin
                        if (owner) begin
                            lsu_resp_valid = 1'b1;
                            lsu_rdata      = mem_rdata;
                        end else begin
                            ifu_resp_valid = 1'b1;
                            ifu_rdata      = mem_rdata;
                        end
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            owner         <= 1'b0;
            streak        <= '0;
            mem_req_valid <= 1'b0;
            mem_addr      <= 32'h0;
            mem_wen       <= 1'b0;
            mem_wdata     <= 32'h0;
            mem_wmask     <= 4'h0;
        end else begin
            state         <= state_nxt;
            mem_req_valid <= grant_lsu || grant_ifu;
            if (grant_lsu) begin
                owner     <= 1'b1;
                mem_addr  <= lsu_addr;
                mem_wen   <= lsu_wen;
                mem_wdata <= lsu_wdata;
                mem_wmask <= lsu_wmask;
                // Only LSU wins taken while the IFU was waiting count toward starvation.
                if (!ifu_req_valid) begin
                    streak <= '0;
                end else if (streak != STREAK_MAX) begin
                    streak <= streak + SW'(1);
                end
            end else if (grant_ifu) begin
                owner     <= 1'b0;
                mem_addr  <= ifu_addr;
                mem_wen   <= 1'b0;
                mem_wdata <= 32'h0;
                mem_wmask <= 4'h0;
                streak    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic, with a
// transaction-level model compared against the DUT on every cycle.
module tb_mem_port_arbiter;

    localparam int MAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_addr;
    logic        ifu_resp_valid;
    logic [31:0] ifu_rdata;
    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic [31:0] lsu_addr;
    logic        lsu_wen;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_wmask;
    logic        lsu_resp_valid;
    logic [31:0] lsu_rdata;
    logic        mem_req_valid;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MAX_LSU_STREAK(MAX)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_addr(mem_addr), .mem_wen(mem_wen),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Memory responder: answers cfg_delay cycles after the cycle following mem_req_valid.
    int          wait_left = -1;
    int          cfg_delay = 0;
    int          cfg_stray = 0;
    bit          cfg_fix   = 1'b0;
    logic [31:0] cfg_rdata = 32'h0;

    always begin
        cyc();
        mem_rdata = cfg_fix ? cfg_rdata : $urandom;
        if (mem_req_valid) begin
            wait_left      = (cfg_delay < 0) ? int'($urandom_range(0, 5)) : cfg_delay;
            mem_resp_valid = (int'($urandom_range(0, 99)) < cfg_stray);
        end else if (wait_left == 0) begin
            mem_resp_valid = 1'b1;
            wait_left      = -1;
        end else if (wait_left > 0) begin
            mem_resp_valid = 1'b0;
            wait_left--;
        end else begin
            mem_resp_valid = (int'($urandom_range(0, 99)) < cfg_stray);
        end
    end

    // Handshake observer: grant order and streak snapshots around IFU grants.
    bit ifu_hs = 1'b0;
    bit lsu_hs = 1'b0;
    bit prev_ifu_hs = 1'b0;
    int grants[$];
    int streak_at_ifu = -1;
    int streak_after_ifu = -1;

    always @(negedge clk) begin
        ifu_hs = ifu_req_valid && ifu_req_ready;
        lsu_hs = lsu_req_valid && lsu_req_ready;
        if (prev_ifu_hs) streak_after_ifu = int'(dut.streak);
        if (ifu_hs) begin
            grants.push_back(0);
            streak_at_ifu = int'(dut.streak);
        end
        if (lsu_hs) grants.push_back(1);
        prev_ifu_hs = ifu_hs;
    end

    // Transaction model: one outstanding job, counted in cycles since its accept.
    bit          model_on = 1'b0;
    bit          m_busy   = 1'b0;
    int          m_age    = 0;
    int          m_streak = 0;
    bit          m_owner  = 1'b0;
    logic [31:0] m_addr   = 32'h0;
    logic        m_wen    = 1'b0;
    logic [31:0] m_wdata  = 32'h0;
    logic [3:0]  m_wmask  = 4'h0;
    bit e_ir, e_lr, e_iv, e_lv, e_req;

    always @(negedge clk) begin
        if (model_on) begin
            e_ir  = 1'b0;
            e_lr  = 1'b0;
            e_iv  = 1'b0;
            e_lv  = 1'b0;
            e_req = m_busy && m_age == 1;
            if (!rst) begin
                if (!m_busy) begin
                    if (lsu_req_valid && !(ifu_req_valid && m_streak == MAX)) e_lr = 1'b1;
                    else if (ifu_req_valid) e_ir = 1'b1;
                end else if (m_age >= 2 && mem_resp_valid) begin
                    if (m_owner) e_lv = 1'b1;
                    else e_iv = 1'b1;
                end
            end
            chk("ifu_req_ready", 32'(ifu_req_ready), 32'(e_ir));
            chk("lsu_req_ready", 32'(lsu_req_ready), 32'(e_lr));
            chk("ifu_resp_valid", 32'(ifu_resp_valid), 32'(e_iv));
            chk("lsu_resp_valid", 32'(lsu_resp_valid), 32'(e_lv));
            chk("mem_req_valid", 32'(mem_req_valid), 32'(e_req));
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_wen", 32'(mem_wen), 32'(m_wen));
            chk("mem_wdata", mem_wdata, m_wdata);
            chk("mem_wmask", 32'(mem_wmask), 32'(m_wmask));
            if (e_iv || e_lv) begin
                chk("ifu_rdata", ifu_rdata, e_iv ? mem_rdata : 32'h0);
                chk("lsu_rdata", lsu_rdata, e_lv ? mem_rdata : 32'h0);
            end
            if (rst) begin
                m_busy = 1'b0; m_streak = 0; m_owner = 1'b0;
                m_addr = 32'h0; m_wen = 1'b0; m_wdata = 32'h0; m_wmask = 4'h0;
            end else if (!m_busy) begin
                if (e_lr) begin
                    m_busy = 1'b1; m_age = 1; m_owner = 1'b1;
                    m_addr = lsu_addr; m_wen = lsu_wen; m_wdata = lsu_wdata; m_wmask = lsu_wmask;
                    m_streak = ifu_req_valid ? ((m_streak + 1 > MAX) ? MAX : m_streak + 1) : 0;
                end else if (e_ir) begin
                    m_busy = 1'b1; m_age = 1; m_owner = 1'b0;
                    m_addr = ifu_addr; m_wen = 1'b0; m_wdata = 32'h0; m_wmask = 4'h0;
                    m_streak = 0;
                end
            end else if (m_age >= 2 && mem_resp_valid) begin
                m_busy = 1'b0;
            end else begin
                m_age++;
            end
        end
    end

    // Masters issue a new request only once the previous one was accepted.
    task automatic drive_masters(input int ip, input int lp);
        if (ifu_hs || !ifu_req_valid) begin
            ifu_req_valid = (int'($urandom_range(0, 99)) < ip);
            ifu_addr      = $urandom;
        end
        if (lsu_hs || !lsu_req_valid) begin
            lsu_req_valid = (int'($urandom_range(0, 99)) < lp);
            lsu_addr      = $urandom;
            lsu_wen       = 1'($urandom_range(0, 1));
            lsu_wdata     = $urandom;
            lsu_wmask     = 4'($urandom_range(0, 15));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int pulses;
    int at;
    int ifu_at;
    int exp_g[6];

    initial begin
        rst = 1'b1;
        ifu_req_valid = 1'b0; ifu_addr = 32'h0;
        lsu_req_valid = 1'b0; lsu_addr = 32'h0; lsu_wen = 1'b0; lsu_wdata = 32'h0; lsu_wmask = 4'h0;
        mem_resp_valid = 1'b0; mem_rdata = 32'h0;
        cyc();
        model_on = 1'b1;
        cyc();
        @(negedge clk);
        chk("rst_mem_req_valid", 32'(mem_req_valid), 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_mem_wmask", 32'(mem_wmask), 32'h0);
        cyc();
        rst = 1'b0;

        // Single IFU fetch with a one-cycle memory.
        cfg_delay = 0; cfg_fix = 1'b1; cfg_rdata = 32'h0000_0413;
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
        @(negedge clk);
        chk("t1_ifu_ready", 32'(ifu_req_ready), 32'h1);
        cyc();
        ifu_req_valid = 1'b0;
        @(negedge clk);
        chk("t1_mem_req", 32'(mem_req_valid), 32'h1);
        chk("t1_mem_addr", mem_addr, 32'h8000_0000);
        chk("t1_mem_wen", 32'(mem_wen), 32'h0);
        cyc();
        @(negedge clk);
        chk("t1_ifu_resp", 32'(ifu_resp_valid), 32'h1);
        chk("t1_ifu_rdata", ifu_rdata, 32'h0000_0413);
        chk("t1_lsu_resp", 32'(lsu_resp_valid), 32'h0);
        cyc();

        // LSU store.
        cfg_fix = 1'b0;
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_1000; lsu_wen = 1'b1;
        lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
        @(negedge clk);
        chk("t2_lsu_ready", 32'(lsu_req_ready), 32'h1);
        cyc();
        lsu_req_valid = 1'b0;
        @(negedge clk);
        chk("t2_mem_wen", 32'(mem_wen), 32'h1);
        chk("t2_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("t2_mem_wmask", 32'(mem_wmask), 32'hF);
        pulses = 0;
        repeat (4) begin
            cyc();
            @(negedge clk);
            if (lsu_resp_valid) pulses++;
        end
        chk("t2_lsu_resp_pulses", 32'(pulses), 32'h1);
        cyc();

        // Both masters saturated: streak limit forces one IFU grant.
        grants.delete();
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b1; lsu_wen = 1'b0;
        for (int i = 0; i < 40 && grants.size() < 6; i++) begin
            cyc();
            drive_masters(100, 100);
        end
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        exp_g = '{1, 1, 1, 1, 0, 1};
        chk("t3_grant_count", 32'(grants.size()), 32'h6);
        for (int i = 0; i < 6 && i < grants.size(); i++) chk("t3_grant_order", 32'(grants[i]), 32'(exp_g[i]));
        chk("t3_streak_at_ifu", 32'(streak_at_ifu), 32'h4);
        chk("t3_streak_after_ifu", 32'(streak_after_ifu), 32'h0);
        repeat (8) cyc();

        // Slow memory: response 5 cycles after the request pulse, IFU kept waiting.
        cfg_delay = 4;
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_2000; lsu_wen = 1'b0;
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0040;
        @(negedge clk);
        chk("t4_lsu_ready", 32'(lsu_req_ready), 32'h1);
        pulses = 0; at = -1; ifu_at = -1;
        for (int i = 1; i <= 8; i++) begin
            cyc();
            if (lsu_hs) lsu_req_valid = 1'b0;
            if (ifu_hs) ifu_req_valid = 1'b0;
            @(negedge clk);
            if (lsu_resp_valid) begin
                pulses++;
                at = i;
            end
            if (ifu_req_ready && ifu_at < 0) ifu_at = i;
        end
        chk("t4_resp_pulses", 32'(pulses), 32'h1);
        chk("t4_resp_cycle", 32'(at), 32'h6);
        chk("t4_ifu_ready_cycle", 32'(ifu_at), 32'h7);
        cyc();
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        repeat (10) cyc();

        // Reset while waiting; the late response must be dropped.
        cfg_delay = 1;
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0100;
        @(negedge clk);
        chk("t5_ifu_ready", 32'(ifu_req_ready), 32'h1);
        cyc();
        ifu_req_valid = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0200;
        @(negedge clk);
        chk("t5_ifu_resp", 32'(ifu_resp_valid), 32'h0);
        chk("t5_lsu_resp", 32'(lsu_resp_valid), 32'h0);
        chk("t5_ifu_ready_after_rst", 32'(ifu_req_ready), 32'h1);
        cyc();
        ifu_req_valid = 1'b0;
        repeat (6) cyc();

        // Stray responses while idle.
        @(negedge clk);
        cfg_stray = 100;
        cyc();
        @(negedge clk);
        chk("t6_ifu_resp", 32'(ifu_resp_valid), 32'h0);
        chk("t6_lsu_resp", 32'(lsu_resp_valid), 32'h0);
        cyc();
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0300;
        @(negedge clk);
        chk("t6_ifu_ready", 32'(ifu_req_ready), 32'h1);
        cfg_stray = 0;
        cyc();
        ifu_req_valid = 1'b0;
        repeat (6) cyc();

        // Random traffic with random latency, strays and resets.
        @(negedge clk);
        cfg_delay = -1;
        cfg_stray = 10;
        for (int i = 0; i < 3000; i++) begin
            cyc();
            rst = (int'($urandom_range(0, 99)) < 2);
            drive_masters(int'($urandom_range(20, 90)), int'($urandom_range(20, 90)));
        end
        cyc();
        rst = 1'b0;
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        @(negedge clk);
        cfg_stray = 0;
        repeat (12) cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single physical memory port (pmem DPI wrapper) between the IFU instruction-fetch master and the LSU load/store master.
- Accepts at most one transaction at a time and drives a one-cycle request pulse to memory. It then waits for the memory response and routes it back to the master that owns the transaction.
- The LSU has priority. A streak counter guarantees IFU forward progress under continuous LSU traffic.

Parameters:
- MAX_LSU_STREAK, 4, max consecutive LSU grants issued while IFU is requesting; after this many, IFU wins the next contested arbitration. Legal range 1..255.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ifu_req_valid  in  1  IFU fetch request
- ifu_req_ready  out  1  arbiter accepts IFU request this cycle
- ifu_addr  in  32  fetch address
- ifu_resp_valid  out  1  fetch data valid (1-cycle pulse)
- ifu_rdata  out  32  fetched instruction
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  arbiter accepts LSU request this cycle
- lsu_addr  in  32  access address
- lsu_wen  in  1  1 = write, 0 = read
- lsu_wdata  in  32  write data
- lsu_wmask  in  4  byte write mask
- lsu_resp_valid  out  1  LSU response valid (1-cycle pulse, also for writes)
- lsu_rdata  out  32  load data
- mem_req_valid  out  1  memory request (exactly 1 cycle per transaction)
- mem_addr  out  32  registered address
- mem_wen  out  1  registered write enable (always 0 for IFU)
- mem_wdata  out  32  registered write data (0 for IFU)
- mem_wmask  out  4  registered mask (0 for IFU)
- mem_resp_valid  in  1  memory response valid
- mem_rdata  in  32  memory read data

Behaviour:
- State machine has three states: IDLE, REQ, WAIT. A registered owner bit records the granted master (0 = IFU, 1 = LSU).
- Reset values: state IDLE, owner 0, streak 0, mem_req_valid 0, mem_addr/mem_wdata 0, mem_wen 0, mem_wmask 0.
- Ready rules:
  - ifu_req_ready and lsu_req_ready are combinational and are only ever 1 in IDLE.
  - At most one ready is 1 in any cycle.
  - Handshake completes when valid && ready. Masters hold their request fields stable until accepted.
- Arbitration in IDLE:
  - Only LSU valid: grant LSU.
  - Only IFU valid: grant IFU.
  - Both valid: grant LSU unless streak == MAX_LSU_STREAK, in which case grant IFU.
- Streak counter, width clog2(MAX_LSU_STREAK+1):
  - LSU grant with IFU also valid: streak increments, saturating at MAX.
  - LSU grant with IFU idle: streak clears to 0.
  - Any IFU grant: streak clears to 0.
- IDLE → REQ on accept. Request fields are latched into the mem_* registers and owner is set.
- REQ: mem_req_valid = 1 for exactly this cycle; next state is WAIT unconditionally. mem_resp_valid is ignored in REQ.
- WAIT:
  - Stays in WAIT until mem_resp_valid = 1.
  - In the mem_resp_valid cycle, the owner's resp_valid = 1 combinationally and its rdata = mem_rdata. The other master's resp_valid = 0.
  - Next state is IDLE.
- Non-owner rdata outputs are 0. resp_valid outputs are 0 outside WAIT.
- Latency with a 1-cycle memory:
  - Accept at cycle N, mem_req_valid at N+1, resp at N+2, next accept at N+3.
  - Peak throughput is one transaction per 3 cycles.
- mem_* registers hold their values after REQ until the next accept. Only mem_req_valid drops.
- mem_resp_valid received in IDLE (stray response) is ignored and produces no master response.
- Reset mid-transaction: state returns to IDLE, the pending response is discarded, and no resp_valid is issued for it.
- IFU writes are impossible: mem_wen, mem_wdata and mem_wmask are forced to 0 on IFU grants.

Test Plan:
- Single IFU fetch of addr 0x80000000, memory returns 0x00000413 one cycle after the request → ifu_req_ready=1 at N, mem_req_valid=1 only at N+1 with mem_wen=0, ifu_resp_valid=1 with ifu_rdata=0x00000413 at N+2, lsu_resp_valid stays 0.
- LSU store of addr 0x80001000, wdata 0xDEADBEEF, wmask 0xF → mem_wen=1, mem_wdata=0xDEADBEEF, mem_wmask=0xF during the REQ cycle; lsu_resp_valid pulses once; ifu_req_ready stays 0 throughout.
- IFU and LSU both valid continuously with MAX_LSU_STREAK=4 → grant order LSU,LSU,LSU,LSU,IFU,LSU…; streak reads 0 after the IFU grant.
- Memory delays the response 5 cycles after mem_req_valid → arbiter holds WAIT; both readies stay 0; exactly one resp pulse, routed to the correct owner.
- rst asserted in WAIT, then memory response arrives one cycle after rst drops → no resp_valid to either master; state IDLE; a new IFU request is accepted immediately.
- Stray mem_resp_valid=1 while in IDLE with no requests → ifu_resp_valid=lsu_resp_valid=0 and the state machine does not change.
